// File: rtl/flash_spi_pkg.sv
// rtl/flash_spi_pkg.sv - shared types and constants for the SPI boot-flash reader
package flash_spi_pkg;

  typedef enum logic [2:0] {IDLE, CMD, DUMMY, DATA, DONE, GAP} state_t;

  localparam logic [7:0] CMD_READ_DEFAULT = 8'h03;
  localparam int CMD_BITS  = 32;
  localparam int DATA_BITS = 32;

  // Flash streams the lowest-address byte first; reassemble as little-endian word.
  function automatic logic [31:0] le_word(input logic [31:0] stream);
    return {stream[7:0], stream[15:8], stream[23:16], stream[31:24]};
  endfunction

endpackage

// File: rtl/spi_flash_reader_if.sv
// rtl/spi_flash_reader_if.sv - core-side read port: request, word address, data, busy
interface spi_flash_reader_if #(
  parameter int ADDR_W = 20
) ();
  logic              rstrb;
  logic [ADDR_W-3:0] word_address;
  logic [31:0]       rdata;
  logic              rbusy;

  modport master (output rstrb, output word_address, input rdata, input rbusy);
  modport slave  (input rstrb, input word_address, output rdata, output rbusy);
endinterface

// File: rtl/spi_clk_strobe.sv
// rtl/spi_clk_strobe.sv - SPI half-period divider; strobes mark the last clk of each phase
module spi_clk_strobe #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic rise_stb,
  output logic fall_stb,
  output logic phase
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          last;

  assign last     = (cnt == CNT_LAST);
  assign rise_stb = en && !phase && last;
  assign fall_stb = en && phase && last;

  // Held cleared while deselected so every transfer starts on a fresh low phase.
  always_ff @(posedge clk) begin
    if (!resetn || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (last) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - fetches one 32-bit little-endian word per request via SPI READ
module spi_flash_reader
  import flash_spi_pkg::*;
#(
  parameter int         CLK_DIV    = 1,
  parameter int         DUMMY_CLKS = 1,
  parameter logic [7:0] CMD_READ   = CMD_READ_DEFAULT,
  parameter int         ADDR_W     = 20
) (
  input  logic              clk,
  input  logic              RESET,
  spi_flash_reader_if.slave bus,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs_n
);
  localparam int GAP_W = $clog2(2 * CLK_DIV + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(2 * CLK_DIV - 1);
  localparam logic [6:0] CMD_LAST  = 7'(CMD_BITS - 1);
  localparam logic [6:0] DATA_LAST = 7'(DATA_BITS - 1);
  // The turnaround count includes the final address pulse, so DUMMY only holds the extra ones.
  localparam bit         HAS_DUMMY  = (DUMMY_CLKS > 1);
  localparam logic [6:0] DUMMY_LAST = 7'((DUMMY_CLKS > 1) ? DUMMY_CLKS - 2 : 0);

  state_t            state;
  logic [6:0]        bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [ADDR_W-3:0] addr_lat;
  logic              pending;
  logic [31:0]       tx_sr;
  logic [30:0]       rx_sr;
  logic [31:0]       rdata_q;
  logic              rbusy_q;

  logic              stb_en;
  logic              rise_stb;
  logic              fall_stb;
  logic              phase;
  logic [ADDR_W-3:0] start_addr;
  logic [31:0]       frame;
  logic [31:0]       rx_next;
  logic              start_go;
  logic              accept;

  assign stb_en     = !spi_cs_n;
  assign start_addr = pending ? addr_lat : bus.word_address;
  assign frame      = {CMD_READ, 24'({start_addr, 2'b00})};
  assign rx_next    = {rx_sr, spi_miso};
  assign start_go   = ((state == IDLE) && bus.rstrb) ||
                      ((state == GAP) && (gap_cnt == GAP_LAST) && (pending || bus.rstrb));
  assign accept     = bus.rstrb && !pending;

  assign bus.rdata = rdata_q;
  assign bus.rbusy = rbusy_q;

  spi_clk_strobe #(.CLK_DIV(CLK_DIV)) u_stb (
    .clk      (clk),
    .resetn   (RESET),
    .en       (stb_en),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .phase    (phase)
  );

  always_ff @(posedge clk) begin
    if (!RESET) begin
      state    <= IDLE;
      spi_cs_n <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      rbusy_q  <= 1'b0;
      rdata_q  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      addr_lat <= '0;
      pending  <= 1'b0;
    end else if (start_go) begin
      state    <= CMD;
      spi_cs_n <= 1'b0;
      spi_clk  <= 1'b0;
      spi_mosi <= frame[31];
      tx_sr    <= {frame[30:0], 1'b0};
      rx_sr    <= '0;
      bit_cnt  <= '0;
      addr_lat <= start_addr;
      pending  <= 1'b0;
      rbusy_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: ;
        CMD: begin
          spi_clk <= phase ^ (rise_stb | fall_stb);
          if (fall_stb) begin
            if (bit_cnt == CMD_LAST) begin
              state    <= HAS_DUMMY ? DUMMY : DATA;
              bit_cnt  <= '0;
              spi_mosi <= 1'b0;
            end else begin
              bit_cnt  <= bit_cnt + 7'd1;
              spi_mosi <= tx_sr[31];
              tx_sr    <= {tx_sr[30:0], 1'b0};
            end
          end
        end
        DUMMY: begin
          spi_clk <= phase ^ (rise_stb | fall_stb);
          if (fall_stb) begin
            if (bit_cnt == DUMMY_LAST) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 7'd1;
            end
          end
        end
        DATA: begin
          spi_clk <= phase ^ (rise_stb | fall_stb);
          if (fall_stb) begin
            rx_sr <= rx_next[30:0];
            if (bit_cnt == DATA_LAST) begin
              state    <= DONE;
              spi_cs_n <= 1'b1;
              spi_clk  <= 1'b0;
              rbusy_q  <= 1'b0;
              rdata_q  <= le_word(rx_next);
              bit_cnt  <= '0;
            end else begin
              bit_cnt <= bit_cnt + 7'd1;
            end
          end
        end
        DONE: begin
          state   <= GAP;
          gap_cnt <= '0;
          if (accept) begin
            pending  <= 1'b1;
            addr_lat <= bus.word_address;
            rbusy_q  <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
            if (accept) begin
              pending  <= 1'b1;
              addr_lat <= bus.word_address;
              rbusy_q  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb/tb_spi_flash_reader.sv - directed bench: three reader configurations, each with a flash model
module tb_spi_flash_reader;
  localparam int ADDR_W = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]       mem [0:15];
  logic              rstrb_d [3];
  logic [ADDR_W-3:0] addr_d [3];
  logic              rst_d [3];

  logic [2:0]  cs_m, sclk_m, mosi_m, rbusy_m;
  logic [31:0] rdata_m [3];
  logic [31:0] cap_m [3];
  int          pulse_m [3];

  int checks = 0;
  int errors = 0;

  // Instance 0: CLK_DIV=1/DUMMY=1, 1: CLK_DIV=2/DUMMY=1, 2: CLK_DIV=1/DUMMY=2.
  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int CD = (g == 1) ? 2 : 1;
    localparam int DC = (g == 2) ? 2 : 1;

    spi_flash_reader_if #(.ADDR_W(ADDR_W)) bus ();
    logic        sclk, mosi, cs_n;
    logic        miso = 1'b0;
    logic        prev = 1'b0;
    int          n = 0;
    int          k;
    logic [31:0] rx = '0;
    logic [31:0] tx = '0;
    logic [31:0] w;

    assign bus.rstrb        = rstrb_d[g];
    assign bus.word_address = addr_d[g];
    assign cs_m[g]    = cs_n;
    assign sclk_m[g]  = sclk;
    assign mosi_m[g]  = mosi;
    assign rbusy_m[g] = bus.rbusy;
    assign rdata_m[g] = bus.rdata;
    assign cap_m[g]   = rx;
    assign pulse_m[g] = n;

    spi_flash_reader #(.CLK_DIV(CD), .DUMMY_CLKS(DC), .CMD_READ(8'h03), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .RESET    (rst_d[g]),
      .bus      (bus),
      .spi_clk  (sclk),
      .spi_mosi (mosi),
      .spi_miso (miso),
      .spi_cs_n (cs_n)
    );

    // Mode-0 flash: captures cmd/address on rising edges, drives data after falling edges.
    always @(negedge clk) begin
      if (cs_n) begin
        n    = 0;
        prev = 1'b0;
        miso = 1'b0;
      end else begin
        if (sclk && !prev) begin
          n = n + 1;
          if (n <= 32) rx = {rx[30:0], mosi};
          if (n == 32) begin
            w  = mem[rx[5:2]];
            tx = {w[7:0], w[15:8], w[23:16], w[31:24]};
          end
        end else if (!sclk && prev) begin
          k    = n + 1 - (32 + DC);
          miso = (k >= 0 && k < 32) ? tx[31-k] : 1'b0;
        end
        prev = sclk;
      end
    end
  end

  task automatic run_read(input int g, input logic [ADDR_W-3:0] a,
                          output int lat, output int cs_low, output int falls);
    logic prev_cs;
    lat = 1; cs_low = 0; falls = 0; prev_cs = cs_m[g];
    addr_d[g] = a; rstrb_d[g] = 1'b1;
    @(negedge clk);
    rstrb_d[g] = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      lat++;
      if (!cs_m[g]) cs_low++;
      if (prev_cs && !cs_m[g]) falls++;
      prev_cs = cs_m[g];
      if (!rbusy_m[g]) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    for (int g = 0; g < 3; g++) begin
      checks++; if (cs_m[g] !== 1'b1) begin errors++; $display("FAIL reset_cs_n[%0d]: got %b expected 1", g, cs_m[g]); end
      checks++; if (rbusy_m[g] !== 1'b0) begin errors++; $display("FAIL reset_rbusy[%0d]: got %b expected 0", g, rbusy_m[g]); end
    end
    checks++; if (sclk_m[0] !== 1'b0) begin errors++; $display("FAIL reset_spi_clk: got %b expected 0", sclk_m[0]); end
    checks++; if (mosi_m[0] !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi_m[0]); end
    checks++; if (rdata_m[0] !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata_m[0]); end
  endtask

  task automatic test_reset_abort();
    int lat, csl, falls;
    addr_d[0] = '0; rstrb_d[0] = 1'b1;
    @(negedge clk);
    rstrb_d[0] = 1'b0;
    for (int cyc = 0; cyc < 500 && pulse_m[0] < 40; cyc++) @(negedge clk);
    checks++; if (pulse_m[0] < 40) begin errors++; $display("FAIL abort_reach_pulse40: got %0d expected 40", pulse_m[0]); end
    rst_d[0] = 1'b0;
    @(negedge clk);
    checks++; if (cs_m[0] !== 1'b1) begin errors++; $display("FAIL abort_cs_n: got %b expected 1", cs_m[0]); end
    checks++; if (sclk_m[0] !== 1'b0) begin errors++; $display("FAIL abort_spi_clk: got %b expected 0", sclk_m[0]); end
    checks++; if (rbusy_m[0] !== 1'b0) begin errors++; $display("FAIL abort_rbusy: got %b expected 0", rbusy_m[0]); end
    checks++; if (rdata_m[0] !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 00000000", rdata_m[0]); end
    rst_d[0] = 1'b1;
    @(negedge clk);
    run_read(0, 18'd0, lat, csl, falls);
    checks++; if (rdata_m[0] !== 32'h12345678) begin errors++; $display("FAIL abort_reread: got %h expected 12345678", rdata_m[0]); end
  endtask

  task automatic test_basic();
    int lat, csl, falls;
    repeat (4) @(negedge clk);
    run_read(0, 18'd0, lat, csl, falls);
    checks++; if (cap_m[0] !== 32'h03000000) begin errors++; $display("FAIL basic_mosi: got %h expected 03000000", cap_m[0]); end
    checks++; if (csl != 128) begin errors++; $display("FAIL basic_cs_low: got %0d expected 128", csl); end
    checks++; if (lat != 130) begin errors++; $display("FAIL basic_latency: got %0d expected 130", lat); end
    checks++; if (rdata_m[0] !== 32'h12345678) begin errors++; $display("FAIL basic_rdata: got %h expected 12345678", rdata_m[0]); end
    checks++; if (falls != 1) begin errors++; $display("FAIL basic_cs_falls: got %0d expected 1", falls); end
  endtask

  task automatic test_clk_div2();
    int lat, csl, falls;
    run_read(1, 18'd5, lat, csl, falls);
    checks++; if (cap_m[1] !== 32'h03000014) begin errors++; $display("FAIL div2_mosi: got %h expected 03000014", cap_m[1]); end
    checks++; if (csl != 256) begin errors++; $display("FAIL div2_cs_low: got %0d expected 256", csl); end
    checks++; if (lat != 258) begin errors++; $display("FAIL div2_latency: got %0d expected 258", lat); end
    checks++; if (rdata_m[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL div2_rdata: got %h expected deadbeef", rdata_m[1]); end
  endtask

  task automatic test_back_to_back();
    int falls = 0, gap = 0, done_seen = 0;
    logic prev_cs = 1'b1;
    logic [31:0] first_word = '0;
    repeat (4) @(negedge clk);
    addr_d[0] = 18'd3; rstrb_d[0] = 1'b1;
    for (int cyc = 0; cyc < 1000 && done_seen < 2; cyc++) begin
      @(negedge clk);
      rstrb_d[0] = 1'b0;
      if (prev_cs && !cs_m[0]) falls++;
      if (falls == 1 && cs_m[0]) gap++;
      prev_cs = cs_m[0];
      if (!rbusy_m[0]) begin
        done_seen++;
        if (done_seen == 1) begin
          first_word = rdata_m[0];
          addr_d[0] = 18'd5; rstrb_d[0] = 1'b1;
        end
      end
    end
    checks++; if (done_seen != 2) begin errors++; $display("FAIL b2b_completions: got %0d expected 2", done_seen); end
    checks++; if (first_word !== 32'hA5C30F96) begin errors++; $display("FAIL b2b_first: got %h expected a5c30f96", first_word); end
    checks++; if (rdata_m[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_second: got %h expected deadbeef", rdata_m[0]); end
    checks++; if (falls != 2) begin errors++; $display("FAIL b2b_cs_falls: got %0d expected 2", falls); end
    checks++; if (gap < 2) begin errors++; $display("FAIL b2b_cs_gap: got %0d expected >=2", gap); end
  endtask

  task automatic test_ignore_busy();
    int falls = 0;
    bit pulsed = 0;
    logic prev_cs = 1'b1;
    repeat (6) @(negedge clk);
    addr_d[0] = 18'd3; rstrb_d[0] = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      rstrb_d[0] = 1'b0;
      if (!pulsed && !cs_m[0] && pulse_m[0] >= 45) begin
        addr_d[0] = 18'd5; rstrb_d[0] = 1'b1; pulsed = 1;
      end
      if (prev_cs && !cs_m[0]) falls++;
      prev_cs = cs_m[0];
    end
    checks++; if (!pulsed) begin errors++; $display("FAIL ignore_reach_data: got 0 expected 1"); end
    checks++; if (falls != 1) begin errors++; $display("FAIL ignore_cs_falls: got %0d expected 1", falls); end
    checks++; if (rdata_m[0] !== 32'hA5C30F96) begin errors++; $display("FAIL ignore_rdata: got %h expected a5c30f96", rdata_m[0]); end
    checks++; if (rbusy_m[0] !== 1'b0) begin errors++; $display("FAIL ignore_rbusy: got %b expected 0", rbusy_m[0]); end
  endtask

  task automatic test_dummy2();
    int lat, csl, falls;
    run_read(2, 18'd5, lat, csl, falls);
    checks++; if (csl != 130) begin errors++; $display("FAIL dummy2_cs_low: got %0d expected 130", csl); end
    checks++; if (lat != 132) begin errors++; $display("FAIL dummy2_latency: got %0d expected 132", lat); end
    checks++; if (rdata_m[2] !== 32'hDEADBEEF) begin errors++; $display("FAIL dummy2_rdata: got %h expected deadbeef", rdata_m[2]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h01010101 * i;
    mem[0] = 32'h12345678;
    mem[3] = 32'hA5C30F96;
    mem[5] = 32'hDEADBEEF;
    for (int g = 0; g < 3; g++) begin
      rst_d[g] = 1'b0; rstrb_d[g] = 1'b0; addr_d[g] = '0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    for (int g = 0; g < 3; g++) rst_d[g] = 1'b1;
    @(negedge clk);
    test_reset_abort();
    test_basic();
    test_clk_div2();
    test_back_to_back();
    test_ignore_busy();
    test_dummy2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
